datapath_sequencer: RTL
=======================

# datapath_sequencer

Multi-cycle control sequencer for the 64-bit datapath: the 32x64 register file, the ALU, and the 256x64 RAM. It accepts one 32-bit instruction at a time through a valid/ready handshake. It then drives register select, ALU function/carry, register-write, RAM-write and writeback-mux controls for the required number of cycles, and pulses `done`. It sits between an instruction source (testbench or future fetch unit) and the datapath top level.

## Interface
Parameters: none; all widths are fixed by the datapath.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: sequencer can accept.
- `instr` in 32: instruction word.
- `signalBits` in 4: ALU status {V,C,N,Z}; bit 2 is carry.
- `readA` out 5: register file port A select.
- `readB` out 5: register file port B select; port B also supplies RAM write data.
- `writeReg` out 5: register file write select.
- `write` out 1: register file write enable.
- `functionsel` out 5: ALU function select.
- `ALUcarry` out 1: ALU carry-in.
- `RAMwrite` out 1: RAM write enable.
- `muxSelect` out 1: writeback source; 0 = ALU, 1 = RAM.
- `busy` out 1: instruction in progress.
- `done` out 1: one-cycle pulse in an instruction's final cycle.
- `status` out 4: latched ALU flags.

## Operation
- Instruction fields:
  - [31:30] class: 00 ALU, 01 LOAD, 10 STORE, 11 NOP.
  - [29:25] FS, [24:20] DA, [19:15] SA, [14:10] SB.
  - [9] CI, [8] UC; [7:0] are ignored.
- States: IDLE, EXEC, MEM.
- IDLE:
  - `instr_ready`=1, `busy`=0.
  - `instr_valid`=1 latches `instr` and moves to EXEC.
- EXEC drives `readA`=SA, `readB`=SB, `functionsel`=FS, `ALUcarry` per Configuration.
  - ALU: `write`=1, `writeReg`=DA, `muxSelect`=0, `done`=1; next IDLE.
  - LOAD: RAM address = ALU output; `write`=0, `RAMwrite`=0; next MEM.
  - STORE: `RAMwrite`=1 (address = ALU output, data = reg[SB]), `done`=1; next IDLE.
  - NOP: no strobes, `done`=1; next IDLE.
- MEM (LOAD only):
  - SA/SB/FS/carry stay held so the RAM address is stable.
  - `write`=1, `writeReg`=DA, `muxSelect`=1, `done`=1; next IDLE.
- Outside EXEC/MEM, `write`, `RAMwrite`, `done` are 0. Select outputs hold their last values.
- DA=0 is an ordinary register; the sequencer applies no special case.

## Timing
- Reset values:
  - State IDLE.
  - All select outputs 0; `functionsel`, `ALUcarry`, `write`, `RAMwrite`, `muxSelect`, `busy`, `done`, `status` all 0.
  - `instr_ready`=0 while `rst` is high, 1 after release.
- Handshake:
  - Transfer occurs on a rising edge where `instr_valid` and `instr_ready` are both 1.
  - `instr` is sampled only at that edge.
  - `instr_valid` while busy is ignored and not queued.
- Latency from the accept edge:
  - ALU, STORE, NOP: 1 cycle in EXEC; the write commits at the next edge.
  - LOAD: 2 cycles (EXEC, MEM). RAM read data is valid the cycle after the address is presented.
- Throughput: the next accept can occur in the IDLE cycle after `done`. Minimum period is 2 cycles (ALU/STORE/NOP) or 3 (LOAD).
- All outputs are registered or decoded from state only. There is no combinational path from `instr` or `signalBits` to any output.
- Reset asserted mid-instruction:
  - `write`, `RAMwrite`, `done` drop immediately.
  - No partial writeback; the instruction is discarded.

## Configuration
- `STATUS_REG_EN` defined:
  - On the EXEC edge of an ALU-class instruction, `status` <= `signalBits`.
  - `ALUcarry` = UC ? `status[2]` : CI, which enables multi-word add chains.
  - LOAD, STORE and NOP leave `status` unchanged.
- Not defined:
  - `status` is constant 0.
  - UC is ignored and `ALUcarry` = CI.

## Test plan
- Reset, then ALU instr FS=2, DA=3, SA=1, SB=2, CI=1:
  - `instr_ready` falls for 1 cycle.
  - EXEC cycle shows `readA`=1, `readB`=2, `writeReg`=3, `functionsel`=2, `ALUcarry`=1, `write`=1, `muxSelect`=0, `done`=1.
  - `instr_ready`=1 again the following cycle.
- LOAD DA=7, SA=4, SB=5:
  - EXEC cycle has `write`=0, `RAMwrite`=0.
  - MEM cycle has `write`=1, `muxSelect`=1, `writeReg`=7, `done`=1, with selects unchanged from EXEC.
  - Total 2 busy cycles.
- STORE SA=4, SB=6: exactly one cycle with `RAMwrite`=1, `readB`=6, `done`=1; `write`=0 throughout.
- Hold `instr_valid`=1 with a NOP, then a second ALU instr presented during the busy cycle: the second instr is accepted only at the next IDLE edge. `done` pulses exactly twice.
- Assert `rst` during LOAD MEM cycle: `write`, `done` go 0 without waiting for a clock edge; after release, state is IDLE and `instr_ready`=1.
- With `STATUS_REG_EN`:
  - ALU instr with `signalBits`=4'b0100 gives `status`=4'b0100.
  - A following ALU instr with UC=1, CI=0 drives `ALUcarry`=1.
  - Without the macro, the same sequence gives `ALUcarry`=0 and `status`=0.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake between an instruction source (master) and the sequencer (slave).
// Latency: none, wires only. Backpressure: the slave holds instr_ready low while busy.
interface datapath_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the 64-bit datapath; STATUS_REG_EN adds latched ALU flags and carry chaining.
// Latency: 1 cycle (ALU/STORE/NOP), 2 cycles (LOAD). Backpressure: instr_ready low while busy; offers are not queued.
module datapath_sequencer (
  input  logic                       clk,
  input  logic                       rst,
  datapath_sequencer_if.slave        ibus,
  input  logic [3:0]                 signalBits,
  output logic [4:0]                 readA,
  output logic [4:0]                 readB,
  output logic [4:0]                 writeReg,
  output logic                       write,
  output logic [4:0]                 functionsel,
  output logic                       ALUcarry,
  output logic                       RAMwrite,
  output logic                       muxSelect,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 status
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;
  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_LOAD  = 2'b01,
    CLS_STORE = 2'b10,
    CLS_NOP   = 2'b11
  } cls_t;

  state_t state;
  cls_t   cls;
  cls_t   in_cls;
  logic   ready_q;
  logic   carry_in;

  assign ibus.instr_ready = ready_q;
  assign in_cls           = cls_t'(ibus.instr[31:30]);

`ifdef STATUS_REG_EN
  // UC selects the carry left by the previous ALU op, for multi-word add chains.
  assign carry_in = ibus.instr[8] ? status[2] : ibus.instr[9];
  logic unused_ign;
  assign unused_ign = ^ibus.instr[7:0];
`else
  assign carry_in = ibus.instr[9];
  logic unused_ign;
  assign unused_ign = ^{ibus.instr[8:0], signalBits};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cls         <= CLS_NOP;
      ready_q     <= 1'b0;
      readA       <= '0;
      readB       <= '0;
      writeReg    <= '0;
      functionsel <= '0;
      ALUcarry    <= 1'b0;
      write       <= 1'b0;
      RAMwrite    <= 1'b0;
      muxSelect   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= '0;
    end else begin
      case (state)
        IDLE: begin
          write    <= 1'b0;
          RAMwrite <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          ready_q  <= 1'b1;
          if (ibus.instr_valid && ready_q) begin
            state       <= EXEC;
            cls         <= in_cls;
            functionsel <= ibus.instr[29:25];
            writeReg    <= ibus.instr[24:20];
            readA       <= ibus.instr[19:15];
            readB       <= ibus.instr[14:10];
            ALUcarry    <= carry_in;
            muxSelect   <= 1'b0;
            busy        <= 1'b1;
            ready_q     <= 1'b0;
            write       <= (in_cls == CLS_ALU);
            RAMwrite    <= (in_cls == CLS_STORE);
            done        <= (in_cls != CLS_LOAD);
          end
        end
        EXEC: begin
          if (cls == CLS_LOAD) begin
            // Selects stay put so the RAM address (ALU output) is stable during the read.
            state     <= MEM;
            write     <= 1'b1;
            muxSelect <= 1'b1;
            done      <= 1'b1;
            RAMwrite  <= 1'b0;
          end else begin
            state    <= IDLE;
            write    <= 1'b0;
            RAMwrite <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ready_q  <= 1'b1;
`ifdef STATUS_REG_EN
            if (cls == CLS_ALU) status <= signalBits;
`endif
          end
        end
        MEM: begin
          state    <= IDLE;
          write    <= 1'b0;
          RAMwrite <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
